// File: rtl/sdram_draw_wr_port_if.sv
// Bundle for the drawing-client write port: client request/accept side,
// the 128-bit Avalon-MM write master toward the SDRAM controller, and the display handshake.
interface sdram_draw_wr_port_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 128
);
    logic                  sdram_wr;
    logic [ADDR_W-1:0]     sdram_addr;
    logic [DATA_W-1:0]     sdram_data;
    logic [DATA_W/8-1:0]   sdram_be;
    logic                  sdram_ac;
    logic                  sdram_wait;
    logic [ADDR_W-1:0]     avm_address;
    logic [DATA_W-1:0]     avm_writedata;
    logic [DATA_W/8-1:0]   avm_byteenable;
    logic                  avm_write;
    logic                  avm_waitrequest;
    logic                  disp_req;
    logic                  disp_grant;
    logic                  wr_idle;

    modport slave (
        input  sdram_wr, sdram_addr, sdram_data, sdram_be, avm_waitrequest, disp_req,
        output sdram_ac, sdram_wait, avm_address, avm_writedata, avm_byteenable,
               avm_write, disp_grant, wr_idle
    );

    modport master (
        output sdram_wr, sdram_addr, sdram_data, sdram_be, avm_waitrequest, disp_req,
        input  sdram_ac, sdram_wait, avm_address, avm_writedata, avm_byteenable,
               avm_write, disp_grant, wr_idle
    );
endinterface

// File: rtl/sdram_draw_wr_port.sv
// Drawing-client SDRAM write port: buffers client writes in a FIFO and drains them to the
// Avalon-MM write master, yielding to the display fetcher. Optional macro: SKIP_NULL_BE_EN.
module sdram_draw_wr_port #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    sdram_draw_wr_port_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W + BE_W;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WRITE = 2'd1,
        M_GRANT = 2'd2
    } state_t;

    logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              sdram_ac_r;
    state_t            state_r;
    state_t            next_state_s;
    logic              avm_write_r;
    logic              disp_grant_r;
    logic [ADDR_W-1:0] avm_address_r;
    logic [DATA_W-1:0] avm_writedata_r;
    logic [BE_W-1:0]   avm_byteenable_r;

    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              load_s;
    logic [PTR_W-1:0]  load_ptr_s;

    assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Accept decision; the cycle after an accept is blanked so the client can drop its request.
    always_comb begin
        accept_s = bus.sdram_wr & ~full_s & ~sdram_ac_r;
`ifdef SKIP_NULL_BE_EN
        push_s   = accept_s & (bus.sdram_be != {BE_W{1'b0}});
`else
        push_s   = accept_s;
`endif
    end

    // Write-buffer storage; contents need no reset because the pointers guard validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {bus.sdram_addr, bus.sdram_data, bus.sdram_be};
        end
    end

    // Buffer pointers, occupancy and the accept pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            sdram_ac_r <= 1'b0;
        end else begin
            sdram_ac_r <= accept_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Master next-state logic; a beat in progress is never cut short by the display request.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        load_ptr_s   = rd_ptr_r;
        case (state_r)
            M_IDLE: begin
                if (bus.disp_req) begin
                    next_state_s = M_GRANT;
                end else if (!empty_s) begin
                    load_s       = 1'b1;
                    next_state_s = M_WRITE;
                end else begin
                    next_state_s = M_IDLE;
                end
            end
            M_WRITE: begin
                if (!bus.avm_waitrequest) begin
                    pop_s = 1'b1;
                    if (bus.disp_req) begin
                        next_state_s = M_GRANT;
                    end else if (count_r > CNT_W'(1)) begin
                        // The entry behind the head is already committed, so chain without a bubble.
                        load_s       = 1'b1;
                        load_ptr_s   = rd_ptr_r + PTR_W'(1);
                        next_state_s = M_WRITE;
                    end else begin
                        next_state_s = M_IDLE;
                    end
                end else begin
                    next_state_s = M_WRITE;
                end
            end
            M_GRANT: begin
                if (!bus.disp_req) begin
                    next_state_s = M_IDLE;
                end else begin
                    next_state_s = M_GRANT;
                end
            end
            default: begin
                next_state_s = M_IDLE;
            end
        endcase
    end

    // State register and registered master/grant outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r          <= M_IDLE;
            avm_write_r      <= 1'b0;
            disp_grant_r     <= 1'b0;
            avm_address_r    <= {ADDR_W{1'b0}};
            avm_writedata_r  <= {DATA_W{1'b0}};
            avm_byteenable_r <= {BE_W{1'b0}};
        end else begin
            state_r      <= next_state_s;
            avm_write_r  <= (next_state_s == M_WRITE);
            disp_grant_r <= (next_state_s == M_GRANT);
            if (load_s) begin
                {avm_address_r, avm_writedata_r, avm_byteenable_r} <= fifo_mem_r[load_ptr_s];
            end
        end
    end

    assign bus.sdram_ac       = sdram_ac_r;
    assign bus.sdram_wait     = bus.disp_req | (count_r >= CNT_W'(FIFO_DEPTH - 1)) | ~reset;
    assign bus.avm_address    = avm_address_r;
    assign bus.avm_writedata  = avm_writedata_r;
    assign bus.avm_byteenable = avm_byteenable_r;
    assign bus.avm_write      = avm_write_r;
    assign bus.disp_grant     = disp_grant_r;
    assign bus.wr_idle        = ~reset | (empty_s & ((state_r == M_IDLE) | (state_r == M_GRANT)));

endmodule

// File: tb/tb_sdram_draw_wr_port.sv
// Directed bench for sdram_draw_wr_port: a scoreboard queue of expected master beats,
// popped by a monitor that samples just before each rising edge.
module tb_sdram_draw_wr_port;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 128;
    localparam int BE_W   = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   beats = 0;
    ent_t exp_q[$];

    sdram_draw_wr_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_draw_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: a beat transfers at the rising edge when avm_write=1 and waitrequest=0.
    always begin
        @(negedge clk);
        #4;
        if (reset === 1'b1 && bus.avm_write === 1'b1 && bus.avm_waitrequest === 1'b0) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got addr %0h, required no write", bus.avm_address);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("beat_addr", 128'(bus.avm_address), 128'(e.addr));
                check("beat_data", bus.avm_writedata, e.data);
                check("beat_be", 128'(bus.avm_byteenable), 128'(e.be));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Raise (or keep) the request and wait for the accept pulse; the caller drops sdram_wr.
    task automatic write_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [BE_W-1:0] b, output int lat);
        int   t0;
        bit   got;
        ent_t e;
        t0 = cycle;
        got = 1'b0;
        bus.sdram_addr = a;
        bus.sdram_data = d;
        bus.sdram_be   = b;
        bus.sdram_wr   = 1'b1;
        e.addr = a;
        e.data = d;
        e.be   = b;
`ifdef SKIP_NULL_BE_EN
        if (b != {BE_W{1'b0}}) exp_q.push_back(e);
`else
        exp_q.push_back(e);
`endif
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.sdram_ac === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        lat = cycle - t0;
        check("accept_seen", 128'(got), 128'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (bus.wr_idle === 1'b1) break;
            step();
        end
        check("idle_reached", 128'(bus.wr_idle), 128'(1));
    endtask

    initial begin
        int   lat;
        int   b0;
        bit   acc;
        bit   got5;
        ent_t e;

        reset = 1'b0;
        bus.sdram_wr = 1'b0;
        bus.sdram_addr = '0;
        bus.sdram_data = '0;
        bus.sdram_be = '0;
        bus.avm_waitrequest = 1'b0;
        bus.disp_req = 1'b0;
        step();
        step();
        check("rst_ac", 128'(bus.sdram_ac), 128'(0));
        check("rst_avm_write", 128'(bus.avm_write), 128'(0));
        check("rst_grant", 128'(bus.disp_grant), 128'(0));
        check("rst_idle", 128'(bus.wr_idle), 128'(1));
        check("rst_wait", 128'(bus.sdram_wait), 128'(1));
        check("rst_addr", 128'(bus.avm_address), 128'(0));
        check("rst_data", bus.avm_writedata, 128'(0));
        check("rst_be", 128'(bus.avm_byteenable), 128'(0));
        reset = 1'b1;
        step();
        check("post_rst_wait", 128'(bus.sdram_wait), 128'(0));

        // Single write with exact timing.
        write_req(22'h100000, 128'h0123456789ABCDEF_FEDCBA9876543210, 16'hFFFF, lat);
        bus.sdram_wr = 1'b0;
        check("single_ac_lat", 128'(lat), 128'(1));
        step();
        check("single_avm_write", 128'(bus.avm_write), 128'(1));
        check("single_addr", 128'(bus.avm_address), 128'(22'h100000));
        step();
        check("single_write_off", 128'(bus.avm_write), 128'(0));
        check("single_idle", 128'(bus.wr_idle), 128'(1));
        check("single_beats", 128'(beats), 128'(1));

        // Fill with waitrequest held: accepts every other cycle, then stall when full.
        bus.avm_waitrequest = 1'b1;
        b0 = beats;
        for (int i = 0; i < 4; i++) begin
            write_req(22'h000200 + 22'(i), 128'hA5A5A5A5_00000000_00000000_00000000 | 128'(i),
                      16'hFFFF, lat);
            check("fill_ac_lat", 128'(lat), (i == 0) ? 128'(1) : 128'(2));
            check("fill_wait", 128'(bus.sdram_wait), (i >= 2) ? 128'(1) : 128'(0));
        end
        e.addr = 22'h000204;
        e.data = 128'hA5A5A5A5_00000000_00000000_00000004;
        e.be   = 16'h0F0F;
        bus.sdram_addr = e.addr;
        bus.sdram_data = e.data;
        bus.sdram_be   = e.be;
        exp_q.push_back(e);
        acc = 1'b0;
        repeat (6) begin
            step();
            if (bus.sdram_ac === 1'b1) acc = 1'b1;
        end
        check("full_no_ac", 128'(acc), 128'(0));
        check("full_wait", 128'(bus.sdram_wait), 128'(1));
        check("full_no_beats", 128'(beats), 128'(b0));
        bus.avm_waitrequest = 1'b0;
        got5 = 1'b0;
        repeat (4) begin
            step();
            if (bus.sdram_ac === 1'b1) begin
                got5 = 1'b1;
                bus.sdram_wr = 1'b0;
            end
        end
        check("drain_consecutive", 128'(beats), 128'(b0 + 4));
        for (int i = 0; i < 10 && !got5; i++) begin
            step();
            if (bus.sdram_ac === 1'b1) begin
                got5 = 1'b1;
                bus.sdram_wr = 1'b0;
            end
        end
        bus.sdram_wr = 1'b0;
        check("fifth_accepted", 128'(got5), 128'(1));
        wait_idle();
        check("fill_beats", 128'(beats), 128'(b0 + 5));

        // Stall hold: fields stay stable while waitrequest is high.
        bus.avm_waitrequest = 1'b1;
        write_req(22'h3ABCDE, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'h00FF, lat);
        bus.sdram_wr = 1'b0;
        step();
        check("stall_write", 128'(bus.avm_write), 128'(1));
        b0 = beats;
        repeat (5) begin
            step();
            check("stall_addr", 128'(bus.avm_address), 128'(22'h3ABCDE));
            check("stall_data", bus.avm_writedata, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
            check("stall_be", 128'(bus.avm_byteenable), 128'(16'h00FF));
        end
        bus.avm_waitrequest = 1'b0;
        step();
        check("stall_one_pop", 128'(beats), 128'(b0 + 1));
        step();
        check("stall_done", 128'(bus.avm_write), 128'(0));
        check("stall_no_extra", 128'(beats), 128'(b0 + 1));

        // Display preemption with two entries queued behind the current beat.
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_req(22'h001000 + 22'(i), 128'h11110000 + 128'(i), 16'hFFFF, lat);
        end
        bus.sdram_wr = 1'b0;
        bus.disp_req = 1'b1;
        step();
        check("pre_still_writing", 128'(bus.avm_write), 128'(1));
        check("pre_no_grant", 128'(bus.disp_grant), 128'(0));
        check("pre_wait", 128'(bus.sdram_wait), 128'(1));
        b0 = beats;
        bus.avm_waitrequest = 1'b0;
        step();
        check("grant_on", 128'(bus.disp_grant), 128'(1));
        check("grant_write_off", 128'(bus.avm_write), 128'(0));
        check("grant_beat_done", 128'(beats), 128'(b0 + 1));
        write_req(22'h001003, 128'h11110003, 16'hF00F, lat);
        bus.sdram_wr = 1'b0;
        check("grant_ac_lat", 128'(lat), 128'(1));
        repeat (3) step();
        check("grant_held", 128'(bus.disp_grant), 128'(1));
        check("grant_no_beats", 128'(beats), 128'(b0 + 1));
        bus.disp_req = 1'b0;
        step();
        check("grant_drop", 128'(bus.disp_grant), 128'(0));
        wait_idle();
        check("grant_drain", 128'(beats), 128'(b0 + 4));

        // All-zero byte enables.
        b0 = beats;
        write_req(22'h002000, 128'h55AA55AA, 16'h0000, lat);
        bus.sdram_wr = 1'b0;
        check("null_ac_lat", 128'(lat), 128'(1));
`ifdef SKIP_NULL_BE_EN
        check("null_idle_at_ac", 128'(bus.wr_idle), 128'(1));
`endif
        repeat (3) step();
`ifdef SKIP_NULL_BE_EN
        check("null_skipped", 128'(beats), 128'(b0));
`else
        check("null_issued", 128'(beats), 128'(b0 + 1));
`endif
        check("null_idle", 128'(bus.wr_idle), 128'(1));

        // Reset in the middle of a write with three entries queued.
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_req(22'h003000 + 22'(i), 128'h77770000 + 128'(i), 16'hFFFF, lat);
        end
        bus.sdram_wr = 1'b0;
        step();
        check("mid_writing", 128'(bus.avm_write), 128'(1));
        reset = 1'b0;
        step();
        check("mid_rst_write", 128'(bus.avm_write), 128'(0));
        check("mid_rst_idle", 128'(bus.wr_idle), 128'(1));
        check("mid_rst_wait", 128'(bus.sdram_wait), 128'(1));
        exp_q.delete();
        reset = 1'b1;
        bus.avm_waitrequest = 1'b0;
        b0 = beats;
        repeat (8) step();
        check("no_stale", 128'(beats), 128'(b0));
        write_req(22'h004000, 128'h99998888, 16'h1234, lat);
        bus.sdram_wr = 1'b0;
        wait_idle();
        check("post_rst_beat", 128'(beats), 128'(b0 + 1));
        check("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_draw_wr_port.md
Name: sdram_draw_wr_port

Overview:
- Responder end of the drawing-client SDRAM write interface: `sdram_wr`/`sdram_addr`/`sdram_data`/`sdram_be` in, `sdram_ac`/`sdram_wait` out.
- Buffers accepted writes in a small FIFO and drains them to the SDRAM controller's 128-bit Avalon-MM write master.
- Yields the SDRAM to the display line fetcher on request, via a `disp_req`/`disp_grant` handshake.
- Sits between the score/combo/note drawing engines and the SDRAM controller.

Parameters:
- ADDR_W, 22, word address width
- DATA_W, 128, data width; byte-enable width is DATA_W/8
- FIFO_DEPTH, 4, write buffer entries, power of two, ≥2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- sdram_wr  in  1  client write request; held until `sdram_ac`
- sdram_addr  in  ADDR_W  client word address
- sdram_data  in  DATA_W  client write data
- sdram_be  in  DATA_W/8  client byte enables
- sdram_ac  out  1  one-cycle accept pulse
- sdram_wait  out  1  advisory: client must not start a new write
- avm_address  out  ADDR_W  master address
- avm_writedata  out  DATA_W  master data
- avm_byteenable  out  DATA_W/8  master byte enables
- avm_write  out  1  master write strobe
- avm_waitrequest  in  1  controller stall
- disp_req  in  1  display fetcher requests the SDRAM
- disp_grant  out  1  port is quiescent; display owns the SDRAM
- wr_idle  out  1  FIFO empty and no write in flight

Behaviour:
- Reset (`reset`=0 at a clk edge):
  - FIFO count goes to 0 and the master returns to M_IDLE.
  - `sdram_ac`, `avm_write`, `disp_grant` go to 0; `avm_address`/`avm_writedata`/`avm_byteenable` go to 0.
  - `wr_idle`=1 and `sdram_wait`=1 while `reset`=0.
  - Reset mid-transfer aborts the in-flight write; this is legal only at system reset.
- Accept rule:
  - At a clk edge with `sdram_wr`=1, FIFO not full and `sdram_ac`=0, push {addr, data, be}.
  - `sdram_ac`=1 for exactly the following cycle (1-cycle latency).
  - While `sdram_ac`=1, no push occurs (blanking). Peak client rate is therefore 1 write per 2 cycles.
  - When the FIFO is full, the request is stalled and `sdram_ac` stays 0 until space frees.
  - Acceptance ignores `sdram_wait` and `disp_req`, so a client already in its write state always completes.
- `sdram_wait` = `disp_req` | (count ≥ FIFO_DEPTH-1) | ~reset. It is combinational from registered state plus `disp_req`.
- Master FSM:
  - M_IDLE:
    - `disp_req` → M_GRANT.
    - Otherwise, FIFO not empty → load head into the `avm_*` registers and go to M_WRITE.
  - M_WRITE:
    - `avm_write`=1; address, data and byte enables are held stable while `avm_waitrequest`=1.
    - On `avm_waitrequest`=0, pop the FIFO, then:
      - `disp_req` → M_GRANT (`avm_write`=0);
      - else FIFO non-empty after pop → load next entry and stay in M_WRITE (back-to-back, no bubble);
      - else → M_IDLE.
  - M_GRANT: `disp_grant`=1, `avm_write`=0. On `disp_req`=0 → M_IDLE, and `disp_grant` drops the next cycle.
  - `disp_req` never preempts a write in progress. The grant latency is the remaining waitrequest cycles + 1.
- FIFO boundary cases:
  - Simultaneous push and pop leaves count unchanged.
  - Push to a full FIFO is impossible by the accept rule.
  - Read/write pointers wrap mod FIFO_DEPTH.
  - An entry pushed into an empty FIFO is visible to M_IDLE the next cycle, so the minimum `sdram_wr`→`avm_write` latency is 2 cycles.
- `wr_idle` = (count==0) & (state==M_IDLE | state==M_GRANT). The frame-flip logic flips only when all drawing engines are done and `wr_idle`=1.
- Address is passed through unmodified; the client applies the frame-buffer offset.

Optional Feature:
- SKIP_NULL_BE_EN, defined:
  - A request with `sdram_be`==0 is acknowledged per the normal rule but not pushed (fully transparent word).
  - It consumes no SDRAM bandwidth and does not change `wr_idle`.
- SKIP_NULL_BE_EN, undefined: all-zero byte-enable words are queued and issued like any other write.

Test Plan:
- Single write: addr=0x100000, data=pattern, be=0xFFFF with waitrequest=0.
  - `sdram_ac` high cycle 1.
  - `avm_write` high cycle 2 with identical fields for 1 cycle.
  - `wr_idle` returns to 1 at cycle 3.
- Fill: client holds `sdram_wr` continuously with waitrequest=1.
  - 4 accepts at cycles 1, 3, 5, 7.
  - `sdram_wait`=1 once count ≥3; no `sdram_ac` while full.
  - Release waitrequest → 4 consecutive `avm_write` beats in order.
- Stall hold: waitrequest=1 for 5 cycles mid-write → `avm_address`/`avm_writedata`/`avm_byteenable` unchanged across all 5 cycles, then a single pop.
- Display preemption: `disp_req`=1 while in M_WRITE with 2 entries queued.
  - Current beat completes, then `disp_grant`=1 and `avm_write`=0.
  - `sdram_ac` still accepts new writes (not full).
  - `disp_req`=0 → `disp_grant`=0 next cycle and the remaining entries drain.
- be=0x0000 write: with SKIP_NULL_BE_EN, `sdram_ac` pulses and no `avm_write` occurs; without it, `avm_write` occurs with `avm_byteenable`=0.
- Reset low during M_WRITE with 3 queued → next cycle `avm_write`=0, `wr_idle`=1, `sdram_wait`=1. After release, no stale entry is ever issued.
